// File: rtl/neural_host_pkg.sv
// Shared definitions for the neural accelerator host sequencer: FSM encoding
// and a width helper for counters.
package neural_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_WAIT    = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_HOLD    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/neural_host_sequencer_if.sv
// Stream and neuron-RAM signals between the host sequencer (master) and its
// surroundings (slave): input words, result words and the RAM external ports.
interface neural_host_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_adr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_rd_adr;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (
    input  in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data,
    output ram_wr_en, ram_wr_adr, ram_wr_data, ram_rd_adr
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data,
    input  ram_wr_en, ram_wr_adr, ram_wr_data, ram_rd_adr
  );
endinterface

// File: rtl/neural_host_sequencer.sv
// Host-side initiator: loads input words into neuron RAM with the accelerator
// held in reset, releases it, waits for completion and streams results out.
module neural_host_sequencer
  import neural_host_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int INPUT_BASE  = 0,
  parameter int INPUT_COUNT = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              acc_reset,
  input  logic              acc_finished,
  input  logic [ADDR_W-1:0] acc_result_base,
  input  logic [ADDR_W-1:0] acc_result_count,
  neural_host_sequencer_if.master bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TW    = clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(INPUT_BASE);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(INPUT_COUNT - 1);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [TW-1:0]     tcnt_q;
  logic [ADDR_W-1:0] base_q, count_q, idx_q, idx_inc;
  logic              error_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_adr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              in_ready_c;

  assign idx_inc = idx_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    acc_reset  = 1'b1;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && cnt_q == LAST_CNT) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_WAIT;
      S_WAIT: begin
        acc_reset = 1'b0;
        if (acc_finished)
          state_d = (acc_result_count == '0) ? S_DONE : S_RD_ADDR;
        else if (tcnt_q == TO_LAST)
          state_d = S_DONE;
      end
      S_RD_ADDR: begin
        acc_reset = 1'b0;
        state_d   = S_RD_DATA;
      end
      S_RD_DATA: begin
        acc_reset = 1'b0;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        acc_reset = 1'b0;
        if (bus.out_ready) state_d = (idx_inc == count_q) ? S_DONE : S_RD_ADDR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, latched accelerator status and registered port outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      tcnt_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_adr_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          cnt_q   <= '0;
          error_q <= 1'b0;
        end
        S_LOAD: if (bus.in_valid) begin
          wr_en_q   <= 1'b1;
          wr_adr_q  <= BASE_A + cnt_q[ADDR_W-1:0];
          wr_data_q <= bus.in_data;
          cnt_q     <= cnt_q + CNT_W'(1);
        end
        S_RELEASE: tcnt_q <= '0;
        S_WAIT: begin
          tcnt_q <= tcnt_q + TW'(1);
          if (acc_finished) begin
            base_q  <= acc_result_base;
            count_q <= acc_result_count;
            idx_q   <= '0;
          end else if (tcnt_q == TO_LAST) begin
            error_q <= 1'b1;
          end
        end
        S_RD_DATA: begin
          out_data_q  <= bus.ram_rd_data;
          out_valid_q <= 1'b1;
        end
        S_HOLD: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          idx_q       <= idx_inc;
        end
        default: ;
      endcase
    end
  end

  // Read address follows the index, so it only moves on an output handshake.
  assign bus.ram_rd_adr  = base_q + idx_q;
  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_adr  = wr_adr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign error           = error_q;

endmodule
